dsec_session_ctrl: RTL and testbench

Session sequencer in front of the DSEC encrypt/compress core. It enforces the three-key load sequence and gates host data words into the core. It tracks in-flight words against core outputs, detects protocol violations and output-side stalls, and reports a latched error code. It sits between the host interface and the core's key/data/handshake ports, replacing ad-hoc key counting.

---
 rtl/dsec_ctrl_pkg.sv | 38 +++
 rtl/dsec_stall_timer.sv | 37 +++
 rtl/dsec_session_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dsec_session_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsec_ctrl_pkg.sv
// Shared definitions for the DSEC session controller: FSM states,
// latched error codes, key slot selectors and the DES key parity helper.
package dsec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY2   = 3'd1,
    ST_KEY3   = 3'd2,
    ST_READY  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [3:0] ERR_NONE         = 4'h0;
  localparam logic [3:0] ERR_NO_KEY       = 4'h1;
  localparam logic [3:0] ERR_KEY_SEQ      = 4'h2;
  localparam logic [3:0] ERR_TIMEOUT      = 4'h3;
  localparam logic [3:0] ERR_KEY_MID_MSG  = 4'h4;
  localparam logic [3:0] ERR_SPURIOUS_OUT = 4'h5;
  localparam logic [3:0] ERR_KEY_PARITY   = 4'h6;

  localparam logic [1:0] KSEL_NONE = 2'd0;
  localparam logic [1:0] KSEL_K1   = 2'd1;
  localparam logic [1:0] KSEL_K2   = 2'd2;
  localparam logic [1:0] KSEL_K3   = 2'd3;

  // A DES key word is well formed when every byte holds an odd number of ones.
  function automatic logic des_odd_parity_ok(input logic [63:0] word);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^word[b*8 +: 8]);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dsec_stall_timer.sv
// Output-side stall watchdog: counts consecutive stalled cycles while
// enabled and flags expiry on the cycle that completes CYCLES of them.
module dsec_stall_timer #(
  parameter int unsigned CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired_o = enable_i && stall_i && (count_q == CW'(CYCLES - 1));

  // Advance on each stalled cycle, hold once expired, restart on any break.
  always_comb begin
    count_d = '0;
    if (enable_i && stall_i) begin
      count_d = expired_o ? count_q : count_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dsec_session_ctrl.sv
// Session sequencer in front of the DSEC core: enforces the three-key load
// order, forwards payload words with one cycle of latency, tracks words in
// flight inside the core and latches the first protocol or output error.
// Build option: define DSEC_KEY_PARITY_EN to reject key words that fail
// DES odd parity (error code 0x6).
module dsec_session_ctrl
  import dsec_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned MAX_OUTSTANDING = 15,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      host_data,
  input  logic             host_valid,
  input  logic             host_key_cfg,
  input  logic             host_last,
  output logic             host_rdy,
  input  logic             clr_err,
  output logic             key_we,
  output logic [1:0]       key_sel,
  output logic [63:0]      key_data,
  output logic [63:0]      core_data,
  output logic             core_valid,
  input  logic             core_rdy,
  input  logic             out_valid,
  input  logic             out_rcvd,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             error,
  output logic [3:0]       error_code
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [3:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic             key_we_q, key_we_d;
  logic [1:0]       key_sel_q, key_sel_d;
  logic [63:0]      key_data_q, key_data_d;
  logic [63:0]      core_data_q, core_data_d;
  logic             core_valid_q, core_valid_d;
  logic [3:0]       error_code_q, error_code_d;

  logic accept;
  logic out_done;
  logic out_dec;
  logic spurious;
  logic timer_en;
  logic timer_expired;
  logic key_par_ok;
  logic fwd_commit;

  state_e           plan_state;
  logic             plan_key_wr;
  logic [1:0]       plan_key_sel;
  logic             plan_fwd;
  logic [CNT_W-1:0] plan_blk;
  logic [3:0]       plan_code;
  logic [3:0]       proto_code;
  logic [3:0]       err_code;

`ifdef DSEC_KEY_PARITY_EN
  assign key_par_ok = des_odd_parity_ok(host_data);
`else
  assign key_par_ok = 1'b1;
`endif

  assign accept   = host_valid && host_rdy;
  assign out_done = out_valid && out_rcvd;
  assign out_dec  = out_done && (outstanding_q != 4'd0);
  assign spurious = out_done && (outstanding_q == 4'd0) && (state_q != ST_ERROR);
  assign timer_en = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

  dsec_stall_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .enable_i (timer_en),
    .stall_i  (out_valid && !out_rcvd),
    .expired_o(timer_expired)
  );

  // Host-side ready depends on the state and, while streaming, on core credit.
  always_comb begin
    host_rdy = 1'b0;
    case (state_q)
      ST_IDLE, ST_KEY2, ST_KEY3: host_rdy = 1'b1;
      ST_READY:                  host_rdy = core_rdy;
      ST_STREAM:                 host_rdy = core_rdy && (outstanding_q < MAX_OUT);
      default:                   host_rdy = 1'b0;
    endcase
  end

  // Next state: plan the normal action, then let any error override it.
  always_comb begin
    plan_state   = state_q;
    plan_key_wr  = 1'b0;
    plan_key_sel = KSEL_NONE;
    plan_fwd     = 1'b0;
    plan_blk     = blk_count_q;
    plan_code    = error_code_q;
    proto_code   = ERR_NONE;
    err_code     = ERR_NONE;

    state_d      = state_q;
    blk_count_d  = blk_count_q;
    error_code_d = error_code_q;
    key_we_d     = 1'b0;
    key_sel_d    = KSEL_NONE;
    key_data_d   = key_data_q;
    core_valid_d = 1'b0;
    core_data_d  = core_data_q;
    fwd_commit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && host_key_cfg) begin
          plan_key_wr  = 1'b1;
          plan_key_sel = KSEL_K1;
          plan_state   = ST_KEY2;
        end else if (accept) begin
          proto_code = ERR_NO_KEY;
        end
      end
      ST_KEY2: begin
        if (accept && host_key_cfg) begin
          plan_key_wr  = 1'b1;
          plan_key_sel = KSEL_K2;
          plan_state   = ST_KEY3;
        end else if (accept) begin
          proto_code = ERR_KEY_SEQ;
        end
      end
      ST_KEY3: begin
        if (accept && host_key_cfg) begin
          plan_key_wr  = 1'b1;
          plan_key_sel = KSEL_K3;
          plan_state   = ST_READY;
        end else if (accept) begin
          proto_code = ERR_KEY_SEQ;
        end
      end
      ST_READY: begin
        if (accept && host_key_cfg) begin
          plan_key_wr  = 1'b1;
          plan_key_sel = KSEL_K1;
          plan_state   = ST_KEY2;
        end else if (accept) begin
          plan_fwd   = 1'b1;
          plan_blk   = CNT_W'(1);
          plan_state = host_last ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept && host_key_cfg) begin
          proto_code = ERR_KEY_MID_MSG;
        end else if (accept) begin
          plan_fwd = 1'b1;
          if (blk_count_q != {CNT_W{1'b1}}) begin
            plan_blk = blk_count_q + CNT_W'(1);
          end
          if (host_last) begin
            plan_state = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((outstanding_q == 4'd0) && !out_valid) begin
          plan_state = ST_READY;
          plan_blk   = '0;
        end
      end
      ST_ERROR: begin
        if (clr_err) begin
          plan_state = ST_IDLE;
          plan_code  = ERR_NONE;
        end
      end
      default: plan_state = ST_IDLE;
    endcase

    if (plan_key_wr && !key_par_ok) begin
      plan_key_wr = 1'b0;
      proto_code  = ERR_KEY_PARITY;
    end

    if (spurious) begin
      err_code = ERR_SPURIOUS_OUT;
    end else if (timer_expired) begin
      err_code = ERR_TIMEOUT;
    end else begin
      err_code = proto_code;
    end

    if (err_code != ERR_NONE) begin
      state_d      = ST_ERROR;
      error_code_d = err_code;
    end else begin
      state_d      = plan_state;
      blk_count_d  = plan_blk;
      error_code_d = plan_code;
      key_we_d     = plan_key_wr;
      fwd_commit   = plan_fwd;
      core_valid_d = plan_fwd;
      if (plan_key_wr) begin
        key_sel_d  = plan_key_sel;
        key_data_d = host_data;
      end
      if (plan_fwd) begin
        core_data_d = host_data;
      end
    end
  end

  // In-flight word count: forwards add one, delivered outputs remove one.
  always_comb begin
    outstanding_d = outstanding_q;
    if (fwd_commit && !out_dec && (outstanding_q != 4'hF)) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!fwd_commit && out_dec) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= '0;
      blk_count_q   <= '0;
      key_we_q      <= 1'b0;
      key_sel_q     <= KSEL_NONE;
      key_data_q    <= '0;
      core_data_q   <= '0;
      core_valid_q  <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      blk_count_q   <= blk_count_d;
      key_we_q      <= key_we_d;
      key_sel_q     <= key_sel_d;
      key_data_q    <= key_data_d;
      core_data_q   <= core_data_d;
      core_valid_q  <= core_valid_d;
      error_code_q  <= error_code_d;
    end
  end

  assign key_we     = key_we_q;
  assign key_sel    = key_sel_q;
  assign key_data   = key_data_q;
  assign core_data  = core_data_q;
  assign core_valid = core_valid_q;
  assign blk_count  = blk_count_q;
  assign busy       = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign error      = (state_q == ST_ERROR);
  assign error_code = error_code_q;

endmodule

// File: tb/tb_dsec_session_ctrl.sv
// Self-checking bench for dsec_session_ctrl: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// session-level reference model (key count, message flags, in-flight count).
// Honours DSEC_KEY_PARITY_EN the same way the design does.
module tb_dsec_session_ctrl;

  localparam int TMO   = 1024;
  localparam int MAXO  = 15;
  localparam int CNT_W = 16;
`ifdef DSEC_KEY_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h1F1F1F1F0E0E0E0E;
  localparam logic [63:0] K3 = 64'hFEDCBA9876543210;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [63:0]      host_data = '0;
  logic             host_valid = 1'b0;
  logic             host_key_cfg = 1'b0;
  logic             host_last = 1'b0;
  logic             host_rdy;
  logic             clr_err = 1'b0;
  logic             key_we;
  logic [1:0]       key_sel;
  logic [63:0]      key_data;
  logic [63:0]      core_data;
  logic             core_valid;
  logic             core_rdy = 1'b0;
  logic             out_valid = 1'b0;
  logic             out_rcvd = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] blk_count;
  logic             error;
  logic [3:0]       error_code;

  int total = 0;
  int bad   = 0;

  // Reference model: number of keys loaded so far, message flags, words in flight.
  bit          mValid = 1'b0;
  bit          mErr, mInMsg, mDrain;
  int          mKeys, mCode, mOut, mBlk, mStall;
  logic        eKeyWe, eCoreValid;
  logic [1:0]  eKeySel;
  logic [63:0] eKeyData, eCoreData;

  always #5 clk = ~clk;

  dsec_session_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .MAX_OUTSTANDING(MAXO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_data   (host_data),
    .host_valid  (host_valid),
    .host_key_cfg(host_key_cfg),
    .host_last   (host_last),
    .host_rdy    (host_rdy),
    .clr_err     (clr_err),
    .key_we      (key_we),
    .key_sel     (key_sel),
    .key_data    (key_data),
    .core_data   (core_data),
    .core_valid  (core_valid),
    .core_rdy    (core_rdy),
    .out_valid   (out_valid),
    .out_rcvd    (out_rcvd),
    .busy        (busy),
    .blk_count   (blk_count),
    .error       (error),
    .error_code  (error_code)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit keyParityAccepted(input logic [63:0] w);
    bit ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (($countones(w[b*8 +: 8]) % 2) == 0) ok = 1'b0;
    end
    return ok || !PAR_EN;
  endfunction

  function automatic logic [63:0] fixParity(input logic [63:0] w);
    logic [63:0] r;
    r = w;
    for (int b = 0; b < 8; b++) begin
      r[b*8] = ~(^r[b*8+1 +: 7]);
    end
    return r;
  endfunction

  function automatic bit modelRdy();
    if (mErr || mDrain) return 1'b0;
    if (mInMsg) return core_rdy && (mOut < MAXO);
    if (mKeys == 3) return core_rdy;
    return 1'b1;
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic modelStep();
    bit acc, done, dec;
    int code;
    if (!rst) begin
      mValid = 1'b1; mErr = 1'b0; mInMsg = 1'b0; mDrain = 1'b0;
      mKeys = 0; mCode = 0; mOut = 0; mBlk = 0; mStall = 0;
      eKeyWe = 1'b0; eKeySel = 2'd0; eKeyData = '0;
      eCoreValid = 1'b0; eCoreData = '0;
      return;
    end
    if (!mValid) return;
    acc  = host_valid && modelRdy();
    done = out_valid && out_rcvd;
    dec  = done && (mOut > 0);
    code = 0;
    if (!mErr) begin
      if (done && mOut == 0) code = 5;
      else if ((mInMsg || mDrain) && out_valid && !out_rcvd && (mStall + 1 >= TMO)) code = 3;
      else if (acc && host_key_cfg && mInMsg) code = 4;
      else if (acc && host_key_cfg && !keyParityAccepted(host_data)) code = 6;
      else if (acc && !host_key_cfg && mKeys < 3) code = (mKeys == 0) ? 1 : 2;
    end
    mStall = (!mErr && (mInMsg || mDrain) && out_valid && !out_rcvd) ? mStall + 1 : 0;
    eKeyWe = 1'b0; eKeySel = 2'd0; eCoreValid = 1'b0;
    if (code != 0) begin
      mErr = 1'b1; mCode = code; mKeys = 0; mInMsg = 1'b0; mDrain = 1'b0;
    end else if (mErr) begin
      if (clr_err) begin
        mErr = 1'b0; mCode = 0;
      end
    end else if (mDrain) begin
      if (mOut == 0 && !out_valid) begin
        mDrain = 1'b0; mBlk = 0;
      end
    end else if (acc && host_key_cfg) begin
      mKeys    = (mKeys == 3) ? 1 : mKeys + 1;
      eKeyWe   = 1'b1;
      eKeySel  = 2'(mKeys);
      eKeyData = host_data;
    end else if (acc) begin
      eCoreValid = 1'b1;
      eCoreData  = host_data;
      mBlk = mInMsg ? ((mBlk == (1 << CNT_W) - 1) ? mBlk : mBlk + 1) : 1;
      if (host_last) begin
        mInMsg = 1'b0; mDrain = 1'b1;
      end else begin
        mInMsg = 1'b1;
      end
      if (mOut < 15) mOut++;
    end
    if (dec) mOut--;
  endtask

  // Compare every output against the model each cycle, then step the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      #2;
      if (mValid) begin
        checkOutput("host_rdy",   64'(host_rdy),   64'(modelRdy()));
        checkOutput("key_we",     64'(key_we),     64'(eKeyWe));
        checkOutput("key_sel",    64'(key_sel),    64'(eKeySel));
        checkOutput("key_data",   key_data,        eKeyData);
        checkOutput("core_valid", 64'(core_valid), 64'(eCoreValid));
        checkOutput("core_data",  core_data,       eCoreData);
        checkOutput("busy",       64'(busy),       64'(mInMsg || mDrain));
        checkOutput("blk_count",  64'(blk_count),  64'(mBlk));
        checkOutput("error",      64'(error),      64'(mErr));
        checkOutput("error_code", 64'(error_code), 64'(mCode));
      end
      modelStep();
    end
  end

  task automatic applyStimulus(input logic v, input logic k, input logic l, input logic [63:0] d,
                               input logic crdy, input logic ov, input logic orc, input logic clr);
    @(negedge clk);
    host_valid = v; host_key_cfg = k; host_last = l; host_data = d;
    core_rdy = crdy; out_valid = ov; out_rcvd = orc; clr_err = clr;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    host_valid = 1'b0; host_key_cfg = 1'b0; host_last = 1'b0; host_data = '0;
    core_rdy = 1'b1; out_valid = 1'b0; out_rcvd = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idleCyc();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendKey(input logic [63:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendPay(input logic [63:0] d, input logic last);
    applyStimulus(1'b1, 1'b0, last, d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clearErr();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    idleCyc();
  endtask

  initial begin : main
    logic [63:0] d;

    // Reset state
    doReset();
    #3;
    checkOutput("rst_host_rdy",   64'(host_rdy),   64'h1);
    checkOutput("rst_error",      64'(error),      64'h0);
    checkOutput("rst_error_code", 64'(error_code), 64'h0);
    checkOutput("rst_blk_count",  64'(blk_count),  64'h0);
    checkOutput("rst_core_valid", 64'(core_valid), 64'h0);
    checkOutput("rst_key_sel",    64'(key_sel),    64'h0);

    // Full session: three keys, four-word message, drain back to READY
    sendKey(K1);
    sendKey(K2);
    #3;
    checkOutput("k1_we",   64'(key_we),  64'h1);
    checkOutput("k1_sel",  64'(key_sel), 64'h1);
    checkOutput("k1_data", key_data,     K1);
    sendKey(K3);
    #3;
    checkOutput("k2_sel", 64'(key_sel), 64'h2);
    sendPay(64'hA1, 1'b0);
    #3;
    checkOutput("k3_sel", 64'(key_sel), 64'h3);
    sendPay(64'hA2, 1'b0);
    #3;
    checkOutput("p1_valid", 64'(core_valid), 64'h1);
    checkOutput("p1_data",  core_data,       64'hA1);
    sendPay(64'hA3, 1'b0);
    sendPay(64'hA4, 1'b1);
    #3;
    checkOutput("p3_blk", 64'(blk_count), 64'h3);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    checkOutput("p4_data",    core_data,     64'hA4);
    checkOutput("drain_blk",  64'(blk_count), 64'h4);
    checkOutput("drain_busy", 64'(busy),      64'h1);
    checkOutput("drain_rdy",  64'(host_rdy),  64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    idleCyc();
    idleCyc();
    #3;
    checkOutput("ready_busy", 64'(busy),      64'h0);
    checkOutput("ready_blk",  64'(blk_count), 64'h0);
    checkOutput("ready_rdy",  64'(host_rdy),  64'h1);

    // Payload before any key
    doReset();
    sendPay(64'hBAD, 1'b0);
    idleCyc();
    #3;
    checkOutput("nokey_error", 64'(error),      64'h1);
    checkOutput("nokey_code",  64'(error_code), 64'h1);
    checkOutput("nokey_cv",    64'(core_valid), 64'h0);
    clearErr();
    #3;
    checkOutput("clr_error", 64'(error),    64'h0);
    checkOutput("clr_rdy",   64'(host_rdy), 64'h1);

    // Payload after a single key, then a key word mid-message
    sendKey(K1);
    sendPay(64'hBAD, 1'b0);
    idleCyc();
    #3;
    checkOutput("keyseq_code", 64'(error_code), 64'h2);
    clearErr();
    sendKey(K1); sendKey(K2); sendKey(K3);
    sendPay(64'hC1, 1'b0);
    sendKey(K1);
    idleCyc();
    #3;
    checkOutput("midmsg_code", 64'(error_code), 64'h4);
    clearErr();

    // Fill to the in-flight limit, then stall the output until timeout
    doReset();
    sendKey(K1); sendKey(K2); sendKey(K3);
    for (int i = 0; i < MAXO; i++) sendPay(64'(i + 16), 1'b0);
    sendPay(64'hDEAD, 1'b0);
    #3;
    checkOutput("full_rdy", 64'(host_rdy), 64'h0);
    for (int i = 0; i < TMO; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == TMO - 1) begin
        #3;
        checkOutput("tmo_not_early", 64'(error), 64'h0);
      end
    end
    idleCyc();
    #3;
    checkOutput("tmo_code", 64'(error_code), 64'h3);
    clearErr();

    // Accept and completion in the same cycle, then a spurious completion
    doReset();
    sendKey(K1); sendKey(K2); sendKey(K3);
    sendPay(64'hE1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'hE2, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    #3;
    checkOutput("same_cycle_ok", 64'(error), 64'h0);
    idleCyc();
    #3;
    checkOutput("spurious_code", 64'(error_code), 64'h5);

    // All-zero key word
    doReset();
    sendKey(64'h0);
    idleCyc();
    #3;
    if (PAR_EN) begin
      checkOutput("par_code", 64'(error_code), 64'h6);
      checkOutput("par_we",   64'(key_we),     64'h0);
    end else begin
      checkOutput("nopar_we",  64'(key_we),  64'h1);
      checkOutput("nopar_sel", 64'(key_sel), 64'h1);
    end

    // Randomized traffic against the model
    doReset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 399) != 0);
      host_valid   = 1'($urandom_range(0, 1));
      host_key_cfg = (mKeys < 3 && !mInMsg) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      host_last    = ($urandom_range(0, 4) == 0);
      d = {$urandom, $urandom};
      if (host_key_cfg && $urandom_range(0, 9) != 0) d = fixParity(d);
      host_data    = d;
      core_rdy     = ($urandom_range(0, 4) != 0);
      out_valid    = (mOut > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      out_rcvd     = ($urandom_range(0, 6) != 0);
      clr_err      = mErr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    end
    rst = 1'b1;
    idleCyc();
    idleCyc();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
